// File: rtl/urv_dm_wb_bridge.sv
// Bridge from the uRV data-memory port to a pipelined Wishbone B4 master.
// Optional bus-cycle timeout is compiled in when URV_DM_TIMEOUT_EN is defined.
module urv_dm_wb_bridge #(
  parameter int g_timeout = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_error_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_STROBE   = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK = 2'd2;

  if (g_timeout < 1 || g_timeout > 65535) begin : g_bad_timeout
    $error("g_timeout must be in 1..65535");
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] data_l_q, data_l_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        load_done_q, load_done_d;
  logic        store_done_q, store_done_d;
  logic        error_q, error_d;
  logic        timeout;

  // The byte offset is dropped: the bus always carries word addresses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^dm_addr_i[1:0];

`ifdef URV_DM_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(g_timeout);
  logic [15:0] cnt_q, cnt_d;
  // Fires on the edge where the busy-cycle count would reach the limit.
  assign timeout = (cnt_q + 16'd1) == TIMEOUT_LIMIT;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    data_l_d     = data_l_q;
    sel_d        = sel_q;
    we_d         = we_q;
    load_done_d  = 1'b0;
    store_done_d = 1'b0;
    error_d      = 1'b0;
`ifdef URV_DM_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A simultaneous load and store resolves to the load.
        if (dm_load_i || dm_store_i) begin
          state_d = ST_STROBE;
          adr_d   = {dm_addr_i[31:2], 2'b00};
          dat_d   = dm_data_s_i;
          we_d    = ~dm_load_i;
          sel_d   = dm_load_i ? 4'b1111 : dm_data_select_i;
`ifdef URV_DM_TIMEOUT_EN
          cnt_d   = 16'd0;
`endif
        end
      end
      ST_STROBE, ST_WAIT_ACK: begin
`ifdef URV_DM_TIMEOUT_EN
        cnt_d = cnt_q + 16'd1;
`endif
        if (wb_err_i || timeout) begin
          state_d      = ST_IDLE;
          error_d      = 1'b1;
          load_done_d  = ~we_q;
          store_done_d = we_q;
          if (!we_q) data_l_d = 32'h0;
        end else if (wb_ack_i) begin
          state_d      = ST_IDLE;
          load_done_d  = ~we_q;
          store_done_d = we_q;
          if (!we_q) data_l_d = wb_dat_i;
        end else if (state_q == ST_STROBE && !wb_stall_i) begin
          state_d = ST_WAIT_ACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_IDLE;
      adr_q        <= 32'h0;
      dat_q        <= 32'h0;
      data_l_q     <= 32'h0;
      sel_q        <= 4'h0;
      we_q         <= 1'b0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      error_q      <= 1'b0;
`ifdef URV_DM_TIMEOUT_EN
      cnt_q        <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      data_l_q     <= data_l_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
      error_q      <= error_d;
`ifdef URV_DM_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  // All outputs are pure register decodes; nothing flows straight from inputs.
  assign dm_ready_o      = (state_q == ST_IDLE);
  assign wb_cyc_o        = (state_q != ST_IDLE);
  assign wb_stb_o        = (state_q == ST_STROBE);
  assign wb_adr_o        = adr_q;
  assign wb_dat_o        = dat_q;
  assign wb_sel_o        = sel_q;
  assign wb_we_o         = we_q;
  assign dm_data_l_o     = data_l_q;
  assign dm_load_done_o  = load_done_q;
  assign dm_store_done_o = store_done_q;
  assign dm_error_o      = error_q;

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// Scenario bench for urv_dm_wb_bridge; completions are checked against a queue of
// expected results pushed when each request is issued.
module tb_urv_dm_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dm_addr, dm_data_s, dm_data_l, wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  dm_sel, wb_sel;
  logic        dm_load, dm_store, dm_ready, load_done, store_done, dm_error;
  logic        wb_we, wb_cyc, wb_stb, wb_stall, wb_ack, wb_err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        is_load;
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sb_q[$];
  exp_t mon_e;

  urv_dm_wb_bridge #(.g_timeout(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .dm_addr_i(dm_addr), .dm_data_s_i(dm_data_s), .dm_data_select_i(dm_sel),
    .dm_load_i(dm_load), .dm_store_i(dm_store), .dm_ready_o(dm_ready),
    .dm_data_l_o(dm_data_l), .dm_load_done_o(load_done), .dm_store_done_o(store_done),
    .dm_error_o(dm_error), .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_sel_o(wb_sel), .wb_we_o(wb_we), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb),
    .wb_stall_i(wb_stall), .wb_ack_i(wb_ack), .wb_err_i(wb_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (load_done === 1'b1 || store_done === 1'b1)) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL done_unexpected: load_done=%0b store_done=%0b, required no done pulse",
                 load_done, store_done);
      end else begin
        mon_e = sb_q.pop_front();
        if (load_done !== mon_e.is_load || store_done !== !mon_e.is_load ||
            dm_error !== mon_e.err || (mon_e.is_load && dm_data_l !== mon_e.data)) begin
          miscompares++;
          $display("FAIL done_result: got load=%0b store=%0b err=%0b data=%h, required load=%0b store=%0b err=%0b data=%h",
                   load_done, store_done, dm_error, dm_data_l,
                   mon_e.is_load, !mon_e.is_load, mon_e.err, mon_e.data);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    vectors++;
    if ({wb_cyc, wb_stb, wb_we, load_done, store_done, dm_error} !== 6'b0 || wb_sel !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl: cyc/stb/we/ld/sd/err=%b sel=%h, required 000000 sel=0",
               {wb_cyc, wb_stb, wb_we, load_done, store_done, dm_error}, wb_sel);
    end
    vectors++;
    if (wb_adr !== 32'h0 || wb_dat_o !== 32'h0 || dm_data_l !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_data: adr=%h dat=%h data_l=%h, required all 0", wb_adr, wb_dat_o, dm_data_l);
    end
    rst_n = 1'b1;
    step();
    vectors++;
    if (dm_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: ready=%b, required 1", dm_ready);
    end
  endtask

  task automatic test_load_basic();
    dm_addr = 32'h0000_1006;
    dm_load = 1'b1;
    sb_q.push_back('{1'b1, 1'b0, 32'hCAFE_BABE});
    step();
    dm_load = 1'b0;
    vectors++;
    if (wb_adr !== 32'h0000_1004 || wb_sel !== 4'hF || wb_we !== 1'b0 ||
        wb_stb !== 1'b1 || wb_cyc !== 1'b1 || dm_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_strobe: adr=%h sel=%h we=%b stb=%b cyc=%b rdy=%b, required 00001004 f 0 1 1 0",
               wb_adr, wb_sel, wb_we, wb_stb, wb_cyc, dm_ready);
    end
    step();
    vectors++;
    if (wb_stb !== 1'b0 || wb_cyc !== 1'b1) begin
      miscompares++;
      $display("FAIL load_wait: stb=%b cyc=%b, required 0 1", wb_stb, wb_cyc);
    end
    wb_ack = 1'b1;
    wb_dat_i = 32'hCAFE_BABE;
    step();
    wb_ack = 1'b0;
    wb_dat_i = 32'h0;
    vectors++;
    if (load_done !== 1'b1 || dm_data_l !== 32'hCAFE_BABE || wb_cyc !== 1'b0 || dm_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL load_latency3: done=%b data=%h cyc=%b rdy=%b, required 1 cafebabe 0 1",
               load_done, dm_data_l, wb_cyc, dm_ready);
    end
    step();
    vectors++;
    if (load_done !== 1'b0 || dm_data_l !== 32'hCAFE_BABE) begin
      miscompares++;
      $display("FAIL load_hold: done=%b data=%h, required 0 cafebabe", load_done, dm_data_l);
    end
  endtask

  task automatic test_store_stall();
    int stb_cnt = 0, rdy_low = 0, done_cnt = 0;
    dm_addr = 32'h20;
    dm_sel = 4'b0100;
    dm_data_s = 32'h5A5A_5A5A;
    dm_store = 1'b1;
    wb_stall = 1'b1;
    sb_q.push_back('{1'b0, 1'b0, 32'h0});
    step();
    dm_store = 1'b0;
    vectors++;
    if (wb_we !== 1'b1 || wb_sel !== 4'b0100 || wb_dat_o !== 32'h5A5A_5A5A || wb_adr !== 32'h20) begin
      miscompares++;
      $display("FAIL store_fields: we=%b sel=%h dat=%h adr=%h, required 1 4 5a5a5a5a 00000020",
               wb_we, wb_sel, wb_dat_o, wb_adr);
    end
    for (int i = 0; i < 10; i++) begin
      if (wb_stb) stb_cnt++;
      if (!dm_ready) rdy_low++;
      if (store_done) done_cnt++;
      if (i == 4) wb_stall = 1'b0;
      wb_ack = (i == 5);
      step();
    end
    vectors++;
    if (stb_cnt != 5 || rdy_low != 6 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL store_stall: stb_cycles=%0d ready_low=%0d done_pulses=%0d, required 5 6 1",
               stb_cnt, rdy_low, done_cnt);
    end
  endtask

  task automatic test_load_err();
    dm_addr = 32'h44;
    dm_load = 1'b1;
    sb_q.push_back('{1'b1, 1'b1, 32'h0});
    step();
    dm_load = 1'b0;
    step();
    wb_err = 1'b1;
    wb_dat_i = 32'h1234_0000;
    step();
    wb_err = 1'b0;
    vectors++;
    if (load_done !== 1'b1 || dm_error !== 1'b1 || dm_data_l !== 32'h0) begin
      miscompares++;
      $display("FAIL load_err: done=%b err=%b data=%h, required 1 1 00000000", load_done, dm_error, dm_data_l);
    end
    step();
    vectors++;
    if (dm_error !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse_width: err=%b, required 0", dm_error);
    end
  endtask

  task automatic test_ack_in_strobe();
    dm_addr = 32'h48;
    dm_load = 1'b1;
    sb_q.push_back('{1'b1, 1'b0, 32'h1234_5678});
    step();
    dm_load = 1'b0;
    wb_ack = 1'b1;
    wb_dat_i = 32'h1234_5678;
    step();
    wb_ack = 1'b0;
    vectors++;
    if (load_done !== 1'b1 || dm_data_l !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL ack_in_strobe: done=%b data=%h, required 1 12345678", load_done, dm_data_l);
    end
    // ack and err together in STROBE count as an error
    dm_load = 1'b1;
    sb_q.push_back('{1'b1, 1'b1, 32'h0});
    step();
    dm_load = 1'b0;
    wb_ack = 1'b1;
    wb_err = 1'b1;
    wb_dat_i = 32'hFFFF_FFFF;
    step();
    wb_ack = 1'b0;
    wb_err = 1'b0;
    vectors++;
    if (load_done !== 1'b1 || dm_error !== 1'b1 || dm_data_l !== 32'h0) begin
      miscompares++;
      $display("FAIL ack_and_err: done=%b err=%b data=%h, required 1 1 00000000", load_done, dm_error, dm_data_l);
    end
    step();
  endtask

  task automatic test_idle_ack();
    int bad = 0;
    wb_ack = 1'b1;
    wb_err = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (load_done || store_done || dm_error || !dm_ready || wb_cyc) bad++;
    end
    wb_ack = 1'b0;
    wb_err = 1'b0;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL idle_ack: disturbed_cycles=%0d, required 0", bad);
    end
  endtask

  task automatic test_load_store_together();
    dm_addr = 32'h80;
    dm_sel = 4'h3;
    dm_data_s = 32'h1111_2222;
    dm_load = 1'b1;
    dm_store = 1'b1;
    sb_q.push_back('{1'b1, 1'b0, 32'hABCD_0123});
    step();
    dm_load = 1'b0;
    dm_store = 1'b0;
    vectors++;
    if (wb_we !== 1'b0 || wb_sel !== 4'hF) begin
      miscompares++;
      $display("FAIL ld_st_both: we=%b sel=%h, required 0 f", wb_we, wb_sel);
    end
    step();
    wb_ack = 1'b1;
    wb_dat_i = 32'hABCD_0123;
    step();
    wb_ack = 1'b0;
    vectors++;
    if (load_done !== 1'b1 || store_done !== 1'b0) begin
      miscompares++;
      $display("FAIL ld_st_done: load_done=%b store_done=%b, required 1 0", load_done, store_done);
    end
    step();
  endtask

  task automatic test_back_to_back();
    dm_addr = 32'h100;
    dm_sel = 4'hF;
    dm_data_s = 32'h0000_000A;
    dm_store = 1'b1;
    sb_q.push_back('{1'b0, 1'b0, 32'h0});
    step();
    dm_store = 1'b0;
    dm_addr = 32'h200;
    dm_load = 1'b1;
    step();
    dm_load = 1'b0;
    vectors++;
    if (wb_adr !== 32'h100 || wb_we !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_ignore: adr=%h we=%b, required 00000100 1", wb_adr, wb_we);
    end
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    vectors++;
    if (store_done !== 1'b1 || dm_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_done: store_done=%b ready=%b, required 1 1", store_done, dm_ready);
    end
    dm_addr = 32'h204;
    dm_load = 1'b1;
    sb_q.push_back('{1'b1, 1'b0, 32'h0000_0077});
    step();
    dm_load = 1'b0;
    vectors++;
    if (wb_stb !== 1'b1 || wb_adr !== 32'h204 || wb_we !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_accept: stb=%b adr=%h we=%b, required 1 00000204 0", wb_stb, wb_adr, wb_we);
    end
    wb_ack = 1'b1;
    wb_dat_i = 32'h0000_0077;
    step();
    wb_ack = 1'b0;
    step();
  endtask

  task automatic test_reset_midcycle();
    int late_done = 0;
    dm_addr = 32'h400;
    dm_load = 1'b1;
    step();
    dm_load = 1'b0;
    step();
    vectors++;
    if (wb_cyc !== 1'b1 || wb_stb !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_pre: cyc=%b stb=%b, required 1 0", wb_cyc, wb_stb);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    vectors++;
    if (wb_cyc !== 1'b0 || dm_ready !== 1'b1 || dm_data_l !== 32'h0 || wb_adr !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid_post: cyc=%b rdy=%b data=%h adr=%h, required 0 1 0 0",
               wb_cyc, dm_ready, dm_data_l, wb_adr);
    end
    wb_ack = 1'b1;
    wb_dat_i = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      step();
      if (load_done || store_done || dm_error) late_done++;
    end
    wb_ack = 1'b0;
    vectors++;
    if (late_done != 0) begin
      miscompares++;
      $display("FAIL rst_late_ack: done_pulses=%0d, required 0", late_done);
    end
  endtask

  task automatic test_timeout();
`ifdef URV_DM_TIMEOUT_EN
    int busy = 0;
    dm_addr = 32'h300;
    dm_load = 1'b1;
    sb_q.push_back('{1'b1, 1'b1, 32'h0});
    step();
    dm_load = 1'b0;
    for (int i = 0; i < 30 && wb_cyc; i++) begin
      busy++;
      step();
    end
    vectors++;
    if (busy != 8 || load_done !== 1'b1 || dm_error !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout: busy_cycles=%0d done=%b err=%b, required 8 1 1", busy, load_done, dm_error);
    end
    step();
`else
    int drops = 0;
    dm_addr = 32'h300;
    dm_load = 1'b1;
    sb_q.push_back('{1'b1, 1'b0, 32'hDEAD_0001});
    step();
    dm_load = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (!wb_cyc) drops++;
      step();
    end
    vectors++;
    if (drops != 0) begin
      miscompares++;
      $display("FAIL no_timeout: cyc_low_cycles=%0d, required 0", drops);
    end
    wb_ack = 1'b1;
    wb_dat_i = 32'hDEAD_0001;
    step();
    wb_ack = 1'b0;
    vectors++;
    if (load_done !== 1'b1 || dm_error !== 1'b0) begin
      miscompares++;
      $display("FAIL late_ack_done: done=%b err=%b, required 1 0", load_done, dm_error);
    end
    step();
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    dm_addr = 32'h0;
    dm_data_s = 32'h0;
    dm_sel = 4'h0;
    dm_load = 1'b0;
    dm_store = 1'b0;
    wb_dat_i = 32'h0;
    wb_stall = 1'b0;
    wb_ack = 1'b0;
    wb_err = 1'b0;
    step();
    test_reset();
    test_load_basic();
    test_store_stall();
    test_load_err();
    test_ack_in_strobe();
    test_idle_ack();
    test_load_store_together();
    test_back_to_back();
    test_reset_midcycle();
    test_timeout();
    repeat (2) step();
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL outstanding: pending_completions=%0d, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
